// File: rtl/mrfm_proc_pkg.sv
// Shared definitions for the multi-channel MRFM processor: CTRL layout,
// default address, width derivations and sequencer states.
package mrfm_proc_pkg;

  localparam logic [6:0] BASE_ADDR_DEF = 7'd64;

  localparam int CTRL_RATE0_LSB   = 0;
  localparam int CTRL_RATE1_LSB   = 8;
  localparam int RATE_W           = 8;
  localparam int CTRL_SHIFT_LSB   = 16;
  localparam int SHIFT_W          = 4;
  localparam int CTRL_MASK_LSB    = 20;
  localparam int MASK_W           = 8;
  localparam int CTRL_OVR_CLR_BIT = 31;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } seq_state_e;

  function automatic int acc_w(input int width);
    return width + 9;
  endfunction

  function automatic int chan_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/mrfm_chan_acc.sv
// One channel of accumulate-and-dump with arithmetic shift and saturation.
// MRFM_PROC_MC_OFFSET_EN adds a per-channel offset subtracted from each sample.
module mrfm_chan_acc
  import mrfm_proc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_stb0,
  input  logic             i_stb1,
  input  logic [WIDTH-1:0] i_sample,
`ifdef MRFM_PROC_MC_OFFSET_EN
  input  logic [WIDTH-1:0] i_offset,
`endif
  input  logic [3:0]       i_shift,
  output logic [WIDTH-1:0] o_res
);

  localparam int ACC_W = acc_w(WIDTH);

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_samp;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_shr;

`ifdef MRFM_PROC_MC_OFFSET_EN
  logic [WIDTH:0] w_diff;
  assign w_diff = {i_sample[WIDTH-1], i_sample} - {i_offset[WIDTH-1], i_offset};
  assign w_samp = {{(ACC_W-WIDTH-1){w_diff[WIDTH]}}, w_diff};
`else
  assign w_samp = {{(ACC_W-WIDTH){i_sample[WIDTH-1]}}, i_sample};
`endif

  // the dumped value includes the sample arriving with the dump strobe
  assign w_sum = r_acc + w_samp;
  assign w_shr = w_sum >>> i_shift;

  // clamp when the bits above the result sign disagree with it
  always_comb begin
    o_res = w_shr[WIDTH-1:0];
    if ((&w_shr[ACC_W-1:WIDTH-1]) || !(|w_shr[ACC_W-1:WIDTH-1])) begin
      o_res = w_shr[WIDTH-1:0];
    end else if (w_shr[ACC_W-1]) begin
      o_res = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      o_res = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // accumulator
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= {ACC_W{1'b0}};
    end else if (i_clr || i_stb1) begin
      r_acc <= {ACC_W{1'b0}};
    end else if (i_stb0) begin
      r_acc <= w_sum;
    end else begin
      r_acc <= r_acc;
    end
  end

endmodule

// File: rtl/strobe_gen.sv
// Divides an input strobe by rate+1; the counter restarts from zero on a
// synchronous clear or while disabled, so the first output needs rate+1 inputs.
module strobe_gen (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       i_srst,
  input  logic       i_enable,
  input  logic [7:0] i_rate,
  input  logic       i_strobe_in,
  output logic       o_strobe
);

  logic [7:0] r_cnt;
  logic       w_hit;

  assign w_hit    = (r_cnt >= i_rate);
  assign o_strobe = i_enable && !i_srst && i_strobe_in && w_hit;

  // input strobe counter
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (i_srst || !i_enable) begin
      r_cnt <= 8'd0;
    end else if (i_strobe_in) begin
      r_cnt <= w_hit ? 8'd0 : r_cnt + 8'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/mrfm_proc_mc.sv
// Multi-channel MRFM front end: strobe cascade, per-channel decimation and a
// frame serialiser onto a valid/ready stream. Offsets need MRFM_PROC_MC_OFFSET_EN.
module mrfm_proc_mc
  import mrfm_proc_pkg::*;
#(
  parameter int         NCH       = 4,
  parameter int         WIDTH     = 16,
  parameter logic [6:0] BASE_ADDR = BASE_ADDR_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [6:0]              serial_addr,
  input  logic [31:0]             serial_data,
  input  logic                    serial_strobe,
  input  logic [NCH*WIDTH-1:0]    signal_in,
  output logic [WIDTH-1:0]        out_data,
  output logic [chan_w(NCH)-1:0]  out_chan,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    frame_strobe,
  output logic                    overrun
);

  localparam int CHW = chan_w(NCH);

  logic [RATE_W-1:0]  r_rate0;
  logic [RATE_W-1:0]  r_rate1;
  logic [SHIFT_W-1:0] r_shift;
  logic [NCH-1:0]     r_mask;
  logic [NCH-1:0]     r_pend;
  logic [WIDTH-1:0]   r_buf [NCH];
  seq_state_e         r_state;

  logic               w_ctrl_wr;
  logic               w_stb0;
  logic               w_stb1;
  logic               w_dump;
  logic [WIDTH-1:0]   w_res [NCH];
  logic [CHW-1:0]     w_first;
  logic [CHW-1:0]     w_next;
  logic [NCH-1:0]     w_first_rest;
  logic [NCH-1:0]     w_next_rest;
  logic               w_unused_bits;

  function automatic logic [CHW-1:0] lowest_idx(input logic [NCH-1:0] m);
    lowest_idx = {CHW{1'b0}};
    for (int k = NCH - 1; k >= 0; k--) begin
      if (m[k]) lowest_idx = CHW'(k);
    end
  endfunction

  assign w_ctrl_wr     = serial_strobe && (serial_addr == BASE_ADDR);
  assign w_dump        = w_stb1 && (r_mask != {NCH{1'b0}});
  assign w_first       = lowest_idx(r_mask);
  assign w_next        = lowest_idx(r_pend);
  assign w_first_rest  = r_mask & (r_mask - NCH'(1));
  assign w_next_rest   = r_pend & (r_pend - NCH'(1));
  assign w_unused_bits = ^serial_data;

  // CTRL register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rate0 <= {RATE_W{1'b0}};
      r_rate1 <= {RATE_W{1'b0}};
      r_shift <= {SHIFT_W{1'b0}};
      r_mask  <= {NCH{1'b0}};
    end else if (w_ctrl_wr) begin
      r_rate0 <= serial_data[CTRL_RATE0_LSB +: RATE_W];
      r_rate1 <= serial_data[CTRL_RATE1_LSB +: RATE_W];
      r_shift <= serial_data[CTRL_SHIFT_LSB +: SHIFT_W];
      r_mask  <= serial_data[CTRL_MASK_LSB +: NCH];
    end else begin
      r_rate0 <= r_rate0;
      r_rate1 <= r_rate1;
      r_shift <= r_shift;
      r_mask  <= r_mask;
    end
  end

  strobe_gen u_stb0 (
    .clock      (clock),
    .rst_n      (reset),
    .i_srst     (w_ctrl_wr),
    .i_enable   (enable),
    .i_rate     (r_rate0),
    .i_strobe_in(1'b1),
    .o_strobe   (w_stb0)
  );

  strobe_gen u_stb1 (
    .clock      (clock),
    .rst_n      (reset),
    .i_srst     (w_ctrl_wr),
    .i_enable   (enable),
    .i_rate     (r_rate1),
    .i_strobe_in(w_stb0),
    .o_strobe   (w_stb1)
  );

`ifdef MRFM_PROC_MC_OFFSET_EN
  logic [WIDTH-1:0] r_offset [NCH];

  // per-channel offsets at the addresses following CTRL
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NCH; k++) r_offset[k] <= {WIDTH{1'b0}};
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (serial_strobe && (serial_addr == BASE_ADDR + 7'(k + 1))) begin
          r_offset[k] <= serial_data[WIDTH-1:0];
        end else begin
          r_offset[k] <= r_offset[k];
        end
      end
    end
  end
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    mrfm_chan_acc #(.WIDTH(WIDTH)) u_acc (
      .clock   (clock),
      .rst_n   (reset),
      .i_clr   (w_ctrl_wr || !enable || !r_mask[k]),
      .i_stb0  (w_stb0),
      .i_stb1  (w_stb1),
      .i_sample(signal_in[k*WIDTH +: WIDTH]),
`ifdef MRFM_PROC_MC_OFFSET_EN
      .i_offset(r_offset[k]),
`endif
      .i_shift (r_shift),
      .o_res   (w_res[k])
    );
  end

  // frame sequencer; r_pend holds channels still to be presented after the current beat
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_pend       <= {NCH{1'b0}};
      out_data     <= {WIDTH{1'b0}};
      out_chan     <= {CHW{1'b0}};
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      frame_strobe <= 1'b0;
      for (int k = 0; k < NCH; k++) r_buf[k] <= {WIDTH{1'b0}};
    end else begin
      frame_strobe <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_dump) begin
            for (int k = 0; k < NCH; k++) r_buf[k] <= w_res[k];
            out_data     <= w_res[w_first];
            out_chan     <= w_first;
            out_last     <= (w_first_rest == {NCH{1'b0}});
            r_pend       <= w_first_rest;
            out_valid    <= 1'b1;
            frame_strobe <= 1'b1;
            r_state      <= SEND;
          end else begin
            r_state <= IDLE;
          end
        end
        SEND: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              r_state   <= IDLE;
            end else begin
              out_data <= r_buf[w_next];
              out_chan <= w_next;
              out_last <= (w_next_rest == {NCH{1'b0}});
              r_pend   <= w_next_rest;
            end
          end else begin
            r_state <= SEND;
          end
        end
        default: begin
          r_state   <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

  // sticky overrun; a new drop wins over a simultaneous clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (w_dump && (r_state == SEND)) begin
      overrun <= 1'b1;
    end else if (w_ctrl_wr && serial_data[CTRL_OVR_CLR_BIT]) begin
      overrun <= 1'b0;
    end else begin
      overrun <= overrun;
    end
  end

endmodule

// File: tb/tb_mrfm_proc_mc.sv
// Self-checking bench for mrfm_proc_mc: randomized frames against an
// arithmetic model of the decimation windows and frame ordering.
module tb_mrfm_proc_mc;
  import mrfm_proc_pkg::*;

  localparam int         NCH   = 4;
  localparam int         WIDTH = 16;
  localparam int         CHW   = chan_w(NCH);
  localparam logic [6:0] BASE  = 7'd64;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 enable = 1'b0;
  logic [6:0]           serial_addr = 7'd0;
  logic [31:0]          serial_data = 32'd0;
  logic                 serial_strobe = 1'b0;
  logic [NCH*WIDTH-1:0] signal_in = '0;
  logic                 out_ready = 1'b0;
  logic [WIDTH-1:0]     out_data;
  logic [CHW-1:0]       out_chan;
  logic                 out_valid;
  logic                 out_last;
  logic                 frame_strobe;
  logic                 overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int offs [NCH];

  mrfm_proc_mc #(.NCH(NCH), .WIDTH(WIDTH), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .serial_addr(serial_addr), .serial_data(serial_data), .serial_strobe(serial_strobe),
    .signal_in(signal_in), .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_strobe(frame_strobe), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    serial_addr   = a;
    serial_data   = d;
    serial_strobe = 1'b1;
    tick();
    serial_strobe = 1'b0;
  endtask

  function automatic logic [31:0] ctrl_word(input int r0, input int r1, input int sh,
                                            input logic [7:0] m, input bit clr);
    return {clr, 3'b000, m, 4'(sh), 8'(r1), 8'(r0)};
  endfunction

  // One configuration: nfr decimation windows with enable high, then enable low.
  // rmode 0: random ready, 1: always ready, 2: ready low for the first 'hold' valid cycles.
  task automatic run_frames(input int r0, input int r1, input int sh, input logic [7:0] mask,
                            input int nfr, input int nexp, input int rmode, input int hold,
                            input bit cmode, input logic [15:0] cval, input bit exp_ovr,
                            input string name);
    int P;
    int ncyc;
    int sum;
    int v;
    int fs_cnt;
    int hcnt;
    bit pv, pr, pl;
    logic [WIDTH-1:0]     pd;
    logic [CHW-1:0]       pc;
    logic [NCH*WIDTH-1:0] vec;
    logic [NCH*WIDTH-1:0] samp [$];
    logic [WIDTH-1:0]     ed [$];
    int                   ec [$];
    bit                   el [$];
    logic [WIDTH-1:0]     od [$];
    int                   oc [$];
    bit                   ol [$];
    int                   hi;
    P    = (r0 + 1) * (r1 + 1);
    ncyc = nfr * P + 48;
    for (int n = 0; n < nfr * P; n++) begin
      for (int k = 0; k < NCH; k++) vec[k*WIDTH +: WIDTH] = cmode ? cval : 16'($urandom);
      samp.push_back(vec);
    end
    hi = -1;
    for (int k = 0; k < NCH; k++) if (mask[k]) hi = k;
    for (int j = 0; j < nexp; j++) begin
      for (int k = 0; k < NCH; k++) begin
        if (mask[k]) begin
          sum = 0;
          for (int n = j * P; n < (j + 1) * P; n++) begin
            if (((n + 1) % (r0 + 1)) == 0) begin
              vec = samp[n];
              v   = $signed(vec[k*WIDTH +: WIDTH]);
              sum = sum + v - offs[k];
            end
          end
          sum = sum >>> sh;
          if (sum > 32767) sum = 32767;
          else if (sum < -32768) sum = -32768;
          ed.push_back(16'(sum));
          ec.push_back(k);
          el.push_back(k == hi);
        end
      end
    end
    wr(BASE, ctrl_word(r0, r1, sh, mask, 1'b0));
    fs_cnt = 0; hcnt = 0; pv = 0; pr = 0; pl = 0; pd = '0; pc = '0;
    for (int n = 0; n < ncyc; n++) begin
      if (frame_strobe) fs_cnt++;
      if (pv && !pr) begin
        check({name, "_hold_data"}, 32'(out_data), 32'(pd));
        check({name, "_hold_chan"}, 32'(out_chan), 32'(pc));
        check({name, "_hold_last"}, 32'(out_last), 32'(pl));
        check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      end
      case (rmode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = (hcnt >= hold);
      endcase
      if (out_valid) hcnt++;
      if (out_valid && out_ready) begin
        od.push_back(out_data);
        oc.push_back(int'(out_chan));
        ol.push_back(out_last);
      end
      enable    = (n < nfr * P);
      signal_in = (n < nfr * P) ? samp[n] : {NCH{16'($urandom)}};
      pv = out_valid; pr = out_ready; pd = out_data; pc = out_chan; pl = out_last;
      tick();
    end
    out_ready = 1'b0;
    check({name, "_beats"}, 32'(od.size()), 32'(ed.size()));
    for (int i = 0; i < ed.size() && i < od.size(); i++) begin
      check({name, "_data"}, 32'(od[i]), 32'(ed[i]));
      check({name, "_chan"}, 32'(oc[i]), 32'(ec[i]));
      check({name, "_last"}, 32'(ol[i]), 32'(el[i]));
    end
    check({name, "_fstrobes"}, 32'(fs_cnt), 32'(nexp));
    check({name, "_overrun"}, 32'(overrun), 32'(exp_ovr));
  endtask

  initial begin
    int r0, r1, sh;
    logic [7:0] m;
    for (int k = 0; k < NCH; k++) offs[k] = 0;

    #2 reset = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_fstrobe", 32'(frame_strobe), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_chan", 32'(out_chan), 32'd0);
    reset = 1'b1;
    tick();

    run_frames(0, 3, 2, 8'hF, 1, 1, 1, 0, 1'b1, 16'd100, 1'b0, "avg100");
    run_frames(0, 3, 0, 8'hF, 1, 1, 1, 0, 1'b1, 16'd100, 1'b0, "sum400");
    run_frames(0, 4, 0, 8'hF, 2, 2, 1, 0, 1'b1, 16'd100, 1'b0, "b2b");

    for (int it = 0; it < 6; it++) begin
      r0 = $urandom_range(0, 2);
      r1 = $urandom_range(0, 3);
      sh = $urandom_range(0, 3);
      m  = 8'($urandom_range(1, 15));
      run_frames(r0, r1, sh, m, 1, 1, 0, 0, 1'b0, 16'd0, 1'b0, "rand");
    end

    run_frames(0, 255, 0, 8'hF, 1, 1, 1, 0, 1'b1, 16'h7FFF, 1'b0, "sat_pos");
    run_frames(0, 255, 0, 8'hF, 1, 1, 1, 0, 1'b1, 16'h8000, 1'b0, "sat_neg");
    run_frames(1, 2, 1, 8'b1010, 1, 1, 2, 3, 1'b0, 16'd0, 1'b0, "mask1010");

    run_frames(0, 3, 0, 8'hF, 2, 1, 2, 10, 1'b0, 16'd0, 1'b1, "ovr");
    wr(BASE, ctrl_word(0, 3, 0, 8'hF, 1'b1));
    check("ovr_clear", 32'(overrun), 32'd0);

    run_frames(0, 1, 0, 8'h0, 1, 0, 1, 0, 1'b0, 16'd0, 1'b0, "mask0");

`ifdef MRFM_PROC_MC_OFFSET_EN
    wr(BASE + 7'd1, 32'd10);
    offs[0] = 10;
    run_frames(0, 0, 0, 8'h1, 1, 1, 1, 0, 1'b1, 16'd110, 1'b0, "offset");
`endif

    wr(BASE, ctrl_word(0, 1, 0, 8'hF, 1'b0));
    enable    = 1'b1;
    out_ready = 1'b0;
    signal_in = {NCH{16'($urandom)}};
    tick();
    tick();
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_reset_valid", 32'(out_valid), 32'd0);
    check("mid_reset_last", 32'(out_last), 32'd0);
    check("mid_reset_ovr", 32'(overrun), 32'd0);
    enable = 1'b0;
    for (int k = 0; k < NCH; k++) offs[k] = 0;
    tick();
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_reset_quiet", 32'(out_valid), 32'd0);
    end
    run_frames(0, 1, 0, 8'hF, 1, 1, 1, 0, 1'b0, 16'd0, 1'b0, "fresh");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
